// File: rtl/mipi_pkg.sv
// Shared MIPI CSI-2 definitions: data-type codes, the 4-byte receive beat and frame-writer states.
package mipi_pkg;

    localparam logic [5:0] RAW8_DT   = 6'h2A;
    localparam logic [5:0] RAW10_DT  = 6'h2B;
    localparam logic [5:0] RGB565_DT = 6'h22;

    // Byte [0] is the earliest pixel of the beat.
    typedef logic [3:0][7:0] beat_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        BETWEEN_LINES,
        IN_LINE
    } fw_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO that accepts two words per push and releases one per pop.
module sync_fifo_fwft #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push2,
    input  logic [WIDTH-1:0]         din0,
    input  logic [WIDTH-1:0]         din1,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign free   = (AW+1)'(DEPTH) - count;
    assign dout   = mem[rd_ptr];

    // The caller guarantees two free slots before push2; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push2) begin
                mem[wr_ptr]          <= din0;
                mem[wr_ptr + AW'(1)] <= din1;
                wr_ptr               <= wr_ptr + AW'(2);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (push2 ? (AW+1)'(2) : (AW+1)'(0)) - (do_pop ? (AW+1)'(1) : (AW+1)'(0));
        end
    end

endmodule

// File: rtl/mipi_frame_writer.sv
// Crops RAW8 MIPI beats to the display window and streams 16-bit SDRAM words into ping-pong frame buffers.
module mipi_frame_writer
    import mipi_pkg::*;
#(
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter int         FIFO_DEPTH = 8,
    parameter int         ADDR_WIDTH = 22,
    parameter logic [5:0] RAW8_DT    = mipi_pkg::RAW8_DT
) (
    input  logic                  mipi_clk,
    input  logic                  reset_n,
    input  beat_t                 image_data,
    input  logic [5:0]            image_data_type,
    input  logic                  image_data_enable,
    input  logic                  frame_start,
    input  logic                  frame_end,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [15:0]           wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  display_buffer,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  sync_err
);

    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / 2;
    localparam int LINE_WORDS  = H_ACTIVE / 2;
    localparam int XW          = $clog2(H_ACTIVE + 1);
    localparam int YW          = $clog2(V_ACTIVE + 1);
    localparam int FW          = ADDR_WIDTH + 16;
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;

    fw_state_t             state, state_n;
    logic [XW-1:0]         x, x_n;
    logic [YW-1:0]         y, y_n;
    logic [ADDR_WIDTH-1:0] ptr, ptr_n;
    logic [ADDR_WIDTH-1:0] line_ptr, line_ptr_n;
    logic [ADDR_WIDTH-1:0] base;
    logic                  wr_buf, wr_buf_n;
    logic                  disp_n, done_n, ovf_n, serr_n;
    logic                  beat, line_end, push, pop;
    logic [CW-1:0]         free;
    logic [FW-1:0]         head;

    assign base = wr_buf ? ADDR_WIDTH'(FRAME_WORDS) : '0;

    always_ff @(posedge mipi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= WAIT_FRAME;
            x              <= '0;
            y              <= '0;
            ptr            <= '0;
            line_ptr       <= '0;
            wr_buf         <= 1'b0;
            display_buffer <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
            sync_err       <= 1'b0;
        end else begin
            state          <= state_n;
            x              <= x_n;
            y              <= y_n;
            ptr            <= ptr_n;
            line_ptr       <= line_ptr_n;
            wr_buf         <= wr_buf_n;
            display_buffer <= disp_n;
            frame_done     <= done_n;
            overflow       <= ovf_n;
            sync_err       <= serr_n;
        end
    end

    // frame_start outranks everything, so a coincident beat is dropped and a mid-frame start restarts the same buffer.
    always_comb begin
        state_n    = state;
        x_n        = x;
        y_n        = y;
        ptr_n      = ptr;
        line_ptr_n = line_ptr;
        wr_buf_n   = wr_buf;
        disp_n     = display_buffer;
        done_n     = 1'b0;
        ovf_n      = overflow;
        serr_n     = sync_err;
        push       = 1'b0;
        beat       = image_data_enable &&
                     ((state == IN_LINE) ||
                      ((state == BETWEEN_LINES) && (image_data_type == RAW8_DT)));
        line_end   = (state == IN_LINE) && !image_data_enable;

        if (frame_start) begin
            if (state == WAIT_FRAME) begin
                ovf_n  = 1'b0;
                serr_n = 1'b0;
            end else begin
                serr_n = 1'b1;
            end
            x_n        = '0;
            y_n        = '0;
            ptr_n      = base;
            line_ptr_n = base;
            state_n    = BETWEEN_LINES;
        end else if (state != WAIT_FRAME) begin
            if (line_end) begin
                x_n        = '0;
                y_n        = (y == YW'(V_ACTIVE)) ? y : y + YW'(1);
                line_ptr_n = line_ptr + ADDR_WIDTH'(LINE_WORDS);
                ptr_n      = line_ptr + ADDR_WIDTH'(LINE_WORDS);
                state_n    = BETWEEN_LINES;
            end else if (beat && !frame_end) begin
                if ((x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE))) begin
                    if (free >= CW'(2)) begin
                        push = 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                x_n     = (x == XW'(H_ACTIVE)) ? x : x + XW'(4);
                ptr_n   = ptr + ADDR_WIDTH'(2);
                state_n = IN_LINE;
            end
            if (frame_end) begin
                disp_n   = wr_buf;
                wr_buf_n = ~wr_buf;
                done_n   = 1'b1;
                state_n  = WAIT_FRAME;
            end
        end
    end

    assign pop = wr_valid && wr_ready;

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mipi_clk),
        .reset_n (reset_n),
        .push2   (push),
        .din0    ({ptr, image_data[1], image_data[0]}),
        .din1    ({ptr + ADDR_WIDTH'(1), image_data[3], image_data[2]}),
        .pop     (pop),
        .dout    (head),
        .valid   (wr_valid),
        .free    (free)
    );

    assign wr_data = head[15:0];
    assign wr_addr = head[FW-1:16];

endmodule

// File: tb/tb_mipi_frame_writer.sv
// Randomized bench for mipi_frame_writer: expected words come from the address/cropping rules applied per beat.
module tb_mipi_frame_writer;
    import mipi_pkg::*;

    localparam int H           = 24;
    localparam int V           = 6;
    localparam int DEPTH       = 8;
    localparam int AW          = 22;
    localparam int FRAME_WORDS = H * V / 2;
    localparam int LINE_WORDS  = H / 2;

    logic          mipi_clk = 1'b0;
    logic          reset_n;
    beat_t         image_data;
    logic [5:0]    image_data_type;
    logic          image_data_enable;
    logic          frame_start;
    logic          frame_end;
    logic          wr_valid;
    logic          wr_ready;
    logic [15:0]   wr_data;
    logic [AW-1:0] wr_addr;
    logic          display_buffer;
    logic          frame_done;
    logic          overflow;
    logic          sync_err;

    int             checks = 0;
    int             fails  = 0;
    logic [AW+15:0] exp_q[$];
    int             model_buf  = 0;
    int             model_disp = 0;
    int             line_idx   = 0;
    bit             in_frame   = 1'b0;
    bit             exp_ovf    = 1'b0;
    bit             exp_serr   = 1'b0;
    bit             use_incr   = 1'b0;
    logic [7:0]     inc_byte   = 8'h00;
    bit             stall_seen = 1'b0;
    logic [15:0]    held_data;
    logic [AW-1:0]  held_addr;

    always #5 mipi_clk = ~mipi_clk;

    mipi_frame_writer #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .RAW8_DT    (RAW8_DT)
    ) dut (
        .mipi_clk          (mipi_clk),
        .reset_n           (reset_n),
        .image_data        (image_data),
        .image_data_type   (image_data_type),
        .image_data_enable (image_data_enable),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .wr_addr           (wr_addr),
        .display_buffer    (display_buffer),
        .frame_done        (frame_done),
        .overflow          (overflow),
        .sync_err          (sync_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mipi_clk);
        #1;
    endtask

    // Scoreboard: every accepted word must be the next expected one, and a stalled head must not move.
    always @(negedge mipi_clk) begin
        logic [AW+15:0] e;
        if (!reset_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                checkOutput("hold_valid", wr_valid, 1);
                checkOutput("hold_data", wr_data, held_data);
                checkOutput("hold_addr", wr_addr, held_addr);
            end
            if (wr_valid && wr_ready) begin
                checkOutput("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", wr_addr, e[AW+15:16]);
                    checkOutput("wr_data", wr_data, e[15:0]);
                end
            end
            stall_seen = wr_valid && !wr_ready;
            held_data  = wr_data;
            held_addr  = wr_addr;
        end
    end

    // One RAW8 line; beats past max_kept inside the window are predicted as dropped.
    task automatic applyStimulus(input int nbeats, input int max_kept);
        int addr;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < 4; k++) begin
                image_data[k] = use_incr ? inc_byte : 8'($urandom);
                if (use_incr) inc_byte++;
            end
            image_data_type   = RAW8_DT;
            image_data_enable = 1'b1;
            if ((4 * b < H) && (line_idx < V)) begin
                if (b < max_kept) begin
                    addr = model_buf * FRAME_WORDS + line_idx * LINE_WORDS + 2 * b;
                    exp_q.push_back({AW'(addr), image_data[1], image_data[0]});
                    exp_q.push_back({AW'(addr + 1), image_data[3], image_data[2]});
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            tick();
        end
        image_data_enable = 1'b0;
        line_idx++;
    endtask

    task automatic drainGap(input bit rand_ready);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
        end
        wr_ready = 1'b1;
        checkOutput("drain_bound", exp_q.size(), 0);
        checkOutput("no_early_done", frame_done, 0);
        tick();
    endtask

    task automatic otherPacket();
        int n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            image_data        = beat_t'($urandom);
            image_data_type   = ($urandom_range(0, 1) == 0) ? 6'h12 : RGB565_DT;
            image_data_enable = 1'b1;
            tick();
        end
        image_data_enable = 1'b0;
        tick();
    endtask

    task automatic runLines(input int nlines, input bit rand_ready);
        for (int l = 0; l < nlines; l++) begin
            if ($urandom_range(0, 2) == 0) otherPacket();
            applyStimulus($urandom_range(1, 9), 99);
            drainGap(rand_ready);
        end
    endtask

    task automatic startFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (in_frame) begin
            exp_serr = 1'b1;
        end else begin
            exp_serr = 1'b0;
            exp_ovf  = 1'b0;
        end
        in_frame = 1'b1;
        line_idx = 0;
        checkOutput("start_sync_err", sync_err, exp_serr);
        checkOutput("start_overflow", overflow, exp_ovf);
        checkOutput("start_display", display_buffer, model_disp);
        checkOutput("start_no_done", frame_done, 0);
    endtask

    task automatic endFrame();
        frame_end = 1'b1;
        tick();
        frame_end  = 1'b0;
        model_disp = model_buf;
        model_buf  = 1 - model_buf;
        in_frame   = 1'b0;
        checkOutput("frame_done_pulse", frame_done, 1);
        checkOutput("end_display", display_buffer, model_disp);
        checkOutput("end_overflow", overflow, exp_ovf);
        checkOutput("end_sync_err", sync_err, exp_serr);
        tick();
        checkOutput("frame_done_clear", frame_done, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        image_data        = '0;
        image_data_type   = '0;
        image_data_enable = 1'b0;
        frame_start       = 1'b0;
        frame_end         = 1'b0;
        wr_ready          = 1'b1;
        repeat (3) tick();
        checkOutput("rst_wr_valid", wr_valid, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_display", display_buffer, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_sync_err", sync_err, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] beats before any frame_start must be ignored");
        for (int i = 0; i < 4; i++) begin
            image_data        = beat_t'($urandom);
            image_data_type   = RAW8_DT;
            image_data_enable = 1'b1;
            tick();
        end
        image_data_enable = 1'b0;
        repeat (4) tick();
        checkOutput("idle_no_words", wr_valid, 0);

        $display("[TB] frame A: incrementing bytes, long/short lines, extra lines, buffer 0");
        use_incr = 1'b1;
        startFrame();
        runLines(V + 2, 1'b0);
        endFrame();
        use_incr = 1'b0;

        $display("[TB] frame B: random data with random back-pressure, buffer 1");
        startFrame();
        runLines(V + 2, 1'b1);
        endFrame();

        $display("[TB] frame C: stalled output fills the FIFO and sets overflow");
        startFrame();
        runLines(2, 1'b0);
        wr_ready = 1'b0;
        applyStimulus(7, DEPTH / 2);
        repeat (12) tick();
        checkOutput("overflow_set", overflow, exp_ovf);
        checkOutput("stall_valid", wr_valid, 1);
        drainGap(1'b0);
        runLines(2, 1'b0);
        endFrame();

        $display("[TB] frame D: reset mid-line with words queued");
        startFrame();
        runLines(1, 1'b0);
        wr_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            image_data        = beat_t'($urandom);
            image_data_type   = RAW8_DT;
            image_data_enable = 1'b1;
            tick();
        end
        checkOutput("pre_reset_valid", wr_valid, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_wr_valid", wr_valid, 0);
        checkOutput("reset_display", display_buffer, 0);
        checkOutput("reset_overflow", overflow, 0);
        exp_q.delete();
        model_buf         = 0;
        model_disp        = 0;
        in_frame          = 1'b0;
        exp_ovf           = 1'b0;
        exp_serr          = 1'b0;
        line_idx          = 0;
        image_data_enable = 1'b0;
        wr_ready          = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] frame E: first frame after reset writes buffer 0");
        startFrame();
        runLines(3, 1'b0);
        endFrame();

        $display("[TB] frame F: second frame_start without frame_end");
        startFrame();
        runLines(2, 1'b0);
        startFrame();
        runLines(V, 1'b0);
        endFrame();

        $display("[TB] frame G: clean start clears sync_err");
        startFrame();
        runLines(2, 1'b1);
        endFrame();

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
